// File: rtl/matrix_pkg.sv
// matrix_pkg: FSM state encoding, accumulator sizing and the saturating clamp.
package matrix_pkg;
    typedef enum logic [2:0] {IDLE, ISSUE, LAST, WRITE, DONE} state_t;

    function automatic int acc_w(input int mw, input int sv);
        return 2 * sv + mw;
    endfunction

    function automatic logic signed [63:0] sat(input logic signed [63:0] v, input int sv);
        logic signed [63:0] hi, lo;
        hi = (64'sd1 <<< (sv - 1)) - 64'sd1;
        lo = -hi - 64'sd1;
        return v > hi ? hi : (v < lo ? lo : v);
    endfunction
endpackage

// File: rtl/matrix_sat.sv
// matrix_sat: clamps a wide signed accumulator to SV bits and flags any clip.
module matrix_sat import matrix_pkg::*; #(
    parameter int AW = 34,
    parameter int SV = 16
) (
    input  logic signed [AW-1:0] acc,
    output logic signed [SV-1:0] q,
    output logic                 clip
);
    logic signed [63:0] wide, s;
    assign wide = {{(64 - AW){acc[AW-1]}}, acc};
    assign s    = sat(wide, SV);
    assign q    = s[SV-1:0];
    assign clip = s != wide;
endmodule

// File: rtl/matrix_mac_engine.sv
// matrix_mac_engine: row-major C = A x B sequencer over registered-read matrix stores.
module matrix_mac_engine import matrix_pkg::*; #(
    parameter int maxWidthLen = 2,
    parameter int sizeValue   = 16
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          start,
    input  logic [maxWidthLen:0]          dim,
    output logic [maxWidthLen-1:0]        a_x,
    output logic [maxWidthLen-1:0]        a_y,
    input  logic signed [sizeValue-1:0]   a_data,
    output logic [maxWidthLen-1:0]        b_x,
    output logic [maxWidthLen-1:0]        b_y,
    input  logic signed [sizeValue-1:0]   b_data,
    output logic [maxWidthLen-1:0]        c_wx,
    output logic [maxWidthLen-1:0]        c_wy,
    output logic signed [sizeValue-1:0]   c_in,
    output logic                          c_w,
    output logic                          busy,
    output logic                          done,
    output logic                          overflow
);
    localparam int MW = maxWidthLen;
    localparam int SV = sizeValue;
    localparam int AW = acc_w(MW, SV);
    localparam logic [MW:0] MAXD = {1'b1, {MW{1'b0}}};

    state_t state, nxt;
    logic [MW:0] dim_q, lim;
    logic [MW-1:0] i, j, k, hi, hj, hk;
    logic signed [AW-1:0] acc, ext;
    logic signed [2*SV-1:0] prod;
    logic k_end, j_end, i_end, clip;

    assign lim   = dim_q - 1'b1;
    assign k_end = {1'b0, k} == lim;
    assign j_end = {1'b0, j} == lim;
    assign i_end = {1'b0, i} == lim;
    assign prod  = a_data * b_data;
    assign ext   = {{MW{prod[2*SV-1]}}, prod};

    matrix_sat #(.AW(AW), .SV(SV)) u_sat (.acc(acc), .q(c_in), .clip(clip));

    always_comb begin
        nxt  = state == IDLE  ? (start ? (dim == '0 ? DONE : ISSUE) : IDLE) :
               state == ISSUE ? (k_end ? LAST : ISSUE) :
               state == LAST  ? WRITE :
               state == WRITE ? ((i_end && j_end) ? DONE : ISSUE) : IDLE;
        a_x  = state == ISSUE ? i : hi;
        a_y  = state == ISSUE ? k : hk;
        b_x  = state == ISSUE ? k : hk;
        b_y  = state == ISSUE ? j : hj;
        c_wx = i;
        c_wy = j;
        c_w  = state == WRITE;
        busy = state == ISSUE || state == LAST || state == WRITE;
        done = state == DONE;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            dim_q    <= '0;
            {i, j, k, hi, hj, hk} <= '0;
            acc      <= '0;
            overflow <= 1'b0;
        end else begin
            state <= nxt;
            if (state == IDLE && start) begin
                dim_q    <= dim > MAXD ? MAXD : dim;
                overflow <= 1'b0;
                {i, j, k} <= '0;
            end else if (state == ISSUE) begin
                {hi, hj, hk} <= {i, j, k};
                k   <= k + 1'b1;
                // data arriving now belongs to the address issued last cycle (k-1)
                acc <= k == '0 ? '0 : acc + ext;
            end else if (state == LAST) begin
                acc <= acc + ext;
            end else if (state == WRITE) begin
                overflow <= overflow | clip;
                k <= '0;
                j <= j_end ? '0 : j + 1'b1;
                i <= j_end ? i + 1'b1 : i;
            end
        end
    end
endmodule

// File: tb/tb_matrix_mac_engine.sv
// tb_matrix_mac_engine: table-driven and hand-sequenced checks with A/B/C memory models.
module tb_matrix_mac_engine;
    logic clk = 0, rst_n = 0, start = 0;
    logic [2:0] dim = 0;
    logic [1:0] a_x, a_y, b_x, b_y, c_wx, c_wy;
    logic signed [7:0] a_data = 0, b_data = 0, c_in;
    logic c_w, busy, done, overflow;
    int errors = 0, checks = 0;

    logic signed [7:0] am [4][4], bm [4][4], cm [4][4];
    typedef struct {int x; int y; int v;} wr_t;
    wr_t wq[$];

    typedef struct {int dim; int af; int bf; int cv; int ovf; int nw; int cyc;} vec_t;
    vec_t tv[9];

    matrix_mac_engine #(.maxWidthLen(2), .sizeValue(8)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .dim(dim),
        .a_x(a_x), .a_y(a_y), .a_data(a_data),
        .b_x(b_x), .b_y(b_y), .b_data(b_data),
        .c_wx(c_wx), .c_wy(c_wy), .c_in(c_in), .c_w(c_w),
        .busy(busy), .done(done), .overflow(overflow)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        a_data <= am[a_x][a_y];
        b_data <= bm[b_x][b_y];
        if (c_w) cm[c_wx][c_wy] <= c_in;
    end

    always @(negedge clk) if (c_w) wq.push_back('{int'(c_wx), int'(c_wy), int'(c_in)});

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic fill(input int af, input int bf);
        for (int x = 0; x < 4; x++)
            for (int y = 0; y < 4; y++) begin
                am[x][y] = 8'(af);
                bm[x][y] = 8'(bf);
                cm[x][y] = 8'sd99;
            end
    endtask

    task automatic run(input int d, input bit poke, output int cyc);
        int bsy;
        bsy = 0;
        wq.delete();
        @(negedge clk); dim = 3'(d); start = 1;
        @(posedge clk); cyc = 1;
        @(negedge clk); start = 0;
        while (!done && cyc < 400) begin
            if (cyc == 2) bsy = int'(busy);
            start = poke && cyc == 5;
            @(posedge clk); cyc++;
            @(negedge clk);
        end
        start = 0;
        chk("done_seen", int'(done), 1);
        chk("busy_mid", bsy, int'(d != 0));
        @(negedge clk);
        chk("done_pulse", int'(done) + int'(busy), 0);
    endtask

    task automatic check_rowmajor(input int d, input int cv);
        int de;
        de = d > 4 ? 4 : d;
        for (int n = 0; n < wq.size(); n++) begin
            chk("wr_pos", wq[n].x * 4 + wq[n].y, (n / de) * 4 + (n % de));
            chk("wr_val", wq[n].v, cv);
        end
    endtask

    initial begin
        int cyc;
        int e1 [4];
        tv[0] = '{4,    1,   2,    8, 0, 16, 97};
        tv[1] = '{2,  127, 127,  127, 1,  4, 17};
        tv[2] = '{2,    1,   1,    2, 0,  4, 17};
        tv[3] = '{7,    2,   3,   24, 0, 16, 97};
        tv[4] = '{3,   -1,   1,   -3, 0,  9, 46};
        tv[5] = '{4, -128,-128,  127, 1, 16, 97};
        tv[6] = '{1, -128, 127, -128, 1,  1,  4};
        tv[7] = '{0,    5,   5,    0, 0,  0,  1};
        tv[8] = '{1,    3,  -4,  -12, 0,  1,  4};
        fill(0, 0);
        #2;
        chk("rst_outs", int'({a_x, a_y, b_x, b_y, c_wx, c_wy, c_in, c_w, busy, done, overflow}), 0);
        @(negedge clk); rst_n = 1;

        for (int t = 0; t < 9; t++) begin
            fill(tv[t].af, tv[t].bf);
            run(tv[t].dim, 0, cyc);
            chk($sformatf("v%0d_cycles", t), cyc, tv[t].cyc);
            chk($sformatf("v%0d_writes", t), wq.size(), tv[t].nw);
            chk($sformatf("v%0d_ovf", t), int'(overflow), tv[t].ovf);
            check_rowmajor(tv[t].dim, tv[t].cv);
        end

        // identity times [[1,2],[3,4]]
        fill(0, 0);
        am[0][0] = 1; am[1][1] = 1;
        bm[0][0] = 1; bm[0][1] = 2; bm[1][0] = 3; bm[1][1] = 4;
        run(2, 0, cyc);
        chk("t1_cycles", cyc, 17);
        chk("t1_writes", wq.size(), 4);
        e1 = '{1, 2, 3, 4};
        for (int n = 0; n < 4; n++) chk("t1_c", int'(cm[n / 2][n % 2]), e1[n]);
        chk("t1_ovf", int'(overflow), 0);

        // negative clamp on a single element
        fill(0, 0);
        am[0][0] = -128; am[0][1] = -128; bm[0][0] = 127; bm[1][0] = 127;
        run(2, 0, cyc);
        chk("t4_c00", int'(cm[0][0]), -128);
        chk("t4_c01", int'(cm[0][1]), 0);
        chk("t4_c11", int'(cm[1][1]), 0);
        chk("t4_ovf", int'(overflow), 1);

        // reset during the third element's ISSUE, then recompute with stray starts
        fill(0, 0);
        am[0][0] = 1; am[1][1] = 1;
        bm[0][0] = 1; bm[0][1] = 2; bm[1][0] = 3; bm[1][1] = 4;
        wq.delete();
        @(negedge clk); dim = 2; start = 1;
        @(negedge clk); start = 0;
        cyc = 0;
        while (wq.size() < 2 && cyc < 100) begin @(negedge clk); cyc++; end
        chk("t6_two_writes", wq.size(), 2);
        @(negedge clk);
        chk("t6_in_issue", int'(busy) * 2 + int'(c_w), 2);
        rst_n = 0;
        #1;
        chk("t6_rst_outs", int'({a_x, a_y, b_x, b_y, c_wx, c_wy, c_in, c_w, busy, done, overflow}), 0);
        repeat (3) @(negedge clk);
        rst_n = 1;
        chk("t6_no_partial", wq.size(), 2);
        chk("t6_c10_untouched", int'(cm[1][0]), 99);
        run(2, 1, cyc);
        chk("t6_cycles", cyc, 17);
        chk("t6_writes", wq.size(), 4);
        for (int n = 0; n < 4; n++) chk("t6_c", int'(cm[n / 2][n % 2]), e1[n]);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
